instr_stream_encoder: RTL and testbench
=======================================

Name: instr_stream_encoder

Overview:
- Producer side of the instruction interface that `control` decodes.
- Accepts symbolic instruction requests (op kind plus register/immediate/target fields) over a valid/ready handshake.
- Encodes each request into a 32-bit MIPS-format word using the same opcode/funct assignments `control` decodes, and writes the words sequentially into instruction memory.
- Used by datapath benches and the boot loader to build programs. Terminates each program with a self-jump word.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- MEM_DEPTH, 256, number of writable words (≤ 2**ADDR_W).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a program at base_addr (ignored unless IDLE).
- base_addr  in  ADDR_W  first word address of the program.
- finish  in  1  one-cycle pulse; ends the program (ignored unless ACCEPT).
- req_valid  in  1  request present.
- req_ready  out  1  encoder can take the request this cycle.
- req_op  in  4  instruction kind code (see Behaviour).
- req_rs, req_rt, req_rd  in  5 each  register fields.
- req_imm  in  16  immediate / branch offset.
- req_target  in  26  jump target field.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded instruction.
- word_count  out  ADDR_W+1  words written in the current program, terminator included.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the terminator has been written.
- err_illegal  out  1  sticky; an undefined req_op was consumed. Cleared by start.
- err_overflow  out  1  sticky; a write was refused because the memory is full. Cleared by start.

Behaviour:
- Reset values: all outputs 0; state IDLE; write pointer 0.
- req_op codes, as 6-bit {opcode, funct}:
  - 0 add R 100000
  - 1 sub R 100010
  - 2 and R 100100
  - 3 or R 100101
  - 4 slt R 101010
  - 5 jmxor R 100011
  - 6 brv R 010100
  - 7 lw 100011
  - 8 sw 101011
  - 9 beq 000100
  - 10 nandi 010000
  - 11 blezal 100100
  - 12 j 000010
  - 13 jalpc 011111
  - 14 baln 011011
  - 15 illegal
- Word formats:
  - R-type: {000000, rs, rt, rd, 5'b0, funct}.
  - I-type: {opcode, rs, rt, imm}.
  - J-type (j, jalpc, baln): {opcode, target}.
  - Unused fields are driven exactly as given. shamt is always 0.
- States:
  - IDLE: req_ready=0. start → ACCEPT; write pointer := base_addr; word_count := 0; both error flags cleared.
  - ACCEPT: req_ready = 1 when pointer < MEM_DEPTH-1, which reserves one word for the terminator.
    - On a transfer (req_valid & req_ready), the encoded word is registered and written the following cycle: mem_we=1, mem_addr = pointer; then pointer+1 and word_count+1.
    - Latency from transfer to mem_we is exactly 1 cycle. Throughput is one word per cycle.
    - finish → TERM.
  - TERM: one cycle; writes {000010, zero-extended pointer} (jump to self), then pointer/count increment → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Illegal op: the request is consumed (ready stays high), no write occurs, err_illegal is set.
- Full: req_ready=0 while pointer = MEM_DEPTH-1. req_valid held high while full sets err_overflow. finish still writes the terminator.
- Simultaneous events:
  - finish in the same cycle as a transfer: the transfer is accepted and written first, the terminator follows in the next cycle.
  - start while busy: ignored.
- mem_addr and mem_wdata are held at their last value when mem_we=0.
- reset mid-operation: immediate return to IDLE; no further writes; words already written are left in memory.

Decomposition:
- Shared package `isa_defs`: 6-bit opcode and funct localparams matching `control`, plus the req_op kind codes. `control` and this block both take their encodings from it.
- Sub-module `instr_word_encode`: purely combinational; takes {op, rs, rt, rd, imm, target} and produces {word, illegal}.
- FSM, pointer and handshake stay in the top module.

Test Plan:
- start at base 0x10; send and $1,$2,$3 (op2 rs=1 rt=2 rd=3); finish → write 0x00221824 at 0x10, then 0x08000011 at 0x11; done pulses; word_count=2.
- Back-to-back valid: lw rs=4 rt=5 imm=0x0008, then nandi rs=1 rt=2 imm=0xFFFF → 0x8C850008 at base, 0x4022FFFF at base+1; writes on consecutive cycles.
- jmxor rs=6 rd=7 → funct 100011, word 0x00C03823; jalpc target=0x0000040 → 0x7C000040.
- req_op=15 mid-stream → no mem_we for that request; err_illegal=1; the next legal request is written at the unchanged pointer; a new start clears err_illegal.
- MEM_DEPTH=4, base 0: three writes fill 0..2; req_ready drops; held req_valid → err_overflow=1; finish writes 0x08000003 at 3.
- reset asserted during ACCEPT with req_valid high → outputs 0 and busy=0 immediately; no mem_we after reset.

Source files
------------

// File: rtl/instr_stream_encoder_pkg.sv
`default_nettype none
// isa_defs: opcode/funct encodings shared with the control decoder, plus request kind codes.
// Rev 1.0
package isa_defs;

    localparam logic [5:0] OPC_RTYPE  = 6'b000000;
    localparam logic [5:0] OPC_LW     = 6'b100011;
    localparam logic [5:0] OPC_SW     = 6'b101011;
    localparam logic [5:0] OPC_BEQ    = 6'b000100;
    localparam logic [5:0] OPC_NANDI  = 6'b010000;
    localparam logic [5:0] OPC_BLEZAL = 6'b100100;
    localparam logic [5:0] OPC_J      = 6'b000010;
    localparam logic [5:0] OPC_JALPC  = 6'b011111;
    localparam logic [5:0] OPC_BALN   = 6'b011011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JMXOR = 6'b100011;
    localparam logic [5:0] FN_BRV   = 6'b010100;

    localparam logic [3:0] OP_ADD     = 4'd0;
    localparam logic [3:0] OP_SUB     = 4'd1;
    localparam logic [3:0] OP_AND     = 4'd2;
    localparam logic [3:0] OP_OR      = 4'd3;
    localparam logic [3:0] OP_SLT     = 4'd4;
    localparam logic [3:0] OP_JMXOR   = 4'd5;
    localparam logic [3:0] OP_BRV     = 4'd6;
    localparam logic [3:0] OP_LW      = 4'd7;
    localparam logic [3:0] OP_SW      = 4'd8;
    localparam logic [3:0] OP_BEQ     = 4'd9;
    localparam logic [3:0] OP_NANDI   = 4'd10;
    localparam logic [3:0] OP_BLEZAL  = 4'd11;
    localparam logic [3:0] OP_J       = 4'd12;
    localparam logic [3:0] OP_JALPC   = 4'd13;
    localparam logic [3:0] OP_BALN    = 4'd14;
    localparam logic [3:0] OP_ILLEGAL = 4'd15;

    typedef enum logic [1:0] {
        FMT_R    = 2'd0,
        FMT_I    = 2'd1,
        FMT_J    = 2'd2,
        FMT_NONE = 2'd3
    } word_fmt_t;

    typedef struct packed {
        word_fmt_t  fmt;
        logic [5:0] opcode;
        logic [5:0] funct;
    } op_info_t;

    function automatic op_info_t op_info(input logic [3:0] op);
        op_info_t info;
        case (op)
            OP_ADD:    info = '{FMT_R, OPC_RTYPE, FN_ADD};
            OP_SUB:    info = '{FMT_R, OPC_RTYPE, FN_SUB};
            OP_AND:    info = '{FMT_R, OPC_RTYPE, FN_AND};
            OP_OR:     info = '{FMT_R, OPC_RTYPE, FN_OR};
            OP_SLT:    info = '{FMT_R, OPC_RTYPE, FN_SLT};
            OP_JMXOR:  info = '{FMT_R, OPC_RTYPE, FN_JMXOR};
            OP_BRV:    info = '{FMT_R, OPC_RTYPE, FN_BRV};
            OP_LW:     info = '{FMT_I, OPC_LW, 6'b0};
            OP_SW:     info = '{FMT_I, OPC_SW, 6'b0};
            OP_BEQ:    info = '{FMT_I, OPC_BEQ, 6'b0};
            OP_NANDI:  info = '{FMT_I, OPC_NANDI, 6'b0};
            OP_BLEZAL: info = '{FMT_I, OPC_BLEZAL, 6'b0};
            OP_J:      info = '{FMT_J, OPC_J, 6'b0};
            OP_JALPC:  info = '{FMT_J, OPC_JALPC, 6'b0};
            OP_BALN:   info = '{FMT_J, OPC_BALN, 6'b0};
            default:   info = '{FMT_NONE, 6'b0, 6'b0};
        endcase
        return info;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_stream_encoder_word_encode.sv
`default_nettype none
// instr_word_encode: combinational request-to-MIPS-word encoder.
// Rev 1.0
module instr_word_encode
    import isa_defs::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    op_info_t info;
    assign info = op_info(op);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (info.fmt)
            FMT_R:   word = {OPC_RTYPE, rs, rt, rd, 5'b0, info.funct};
            FMT_I:   word = {info.opcode, rs, rt, imm};
            FMT_J:   word = {info.opcode, target};
            default: illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_stream_encoder.sv
`default_nettype none
// instr_stream_encoder: writes encoded instruction requests into memory, ending with a self-jump.
// Rev 1.0
module instr_stream_encoder
    import isa_defs::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_overflow
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_TERM   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Pointer is one bit wider than the address so the last-word test never wraps.
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(MEM_DEPTH - 1);
    localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

    logic [1:0]      state;
    logic [ADDR_W:0] ptr;
    logic [31:0]     enc_word;
    logic            enc_illegal;
    logic            transfer;

    instr_word_encode u_encode (
        .op      (req_op),
        .rs      (req_rs),
        .rt      (req_rt),
        .rd      (req_rd),
        .imm     (req_imm),
        .target  (req_target),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign req_ready = (state == S_ACCEPT) && (ptr < LAST_PTR);
    assign transfer  = req_valid && req_ready;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            ptr          <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            word_count   <= '0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_ACCEPT;
                        ptr          <= {1'b0, base_addr};
                        word_count   <= '0;
                        err_illegal  <= 1'b0;
                        err_overflow <= 1'b0;
                    end
                end
                S_ACCEPT: begin
                    if (transfer) begin
                        if (enc_illegal) begin
                            err_illegal <= 1'b1;
                        end else begin
                            mem_we     <= 1'b1;
                            mem_addr   <= ptr[ADDR_W-1:0];
                            mem_wdata  <= enc_word;
                            ptr        <= ptr + ONE;
                            word_count <= word_count + ONE;
                        end
                    end
                    if (req_valid && !req_ready) begin
                        err_overflow <= 1'b1;
                    end
                    if (finish) begin
                        state <= S_TERM;
                    end
                end
                S_TERM: begin
                    // Terminator jumps to its own address so the core parks there.
                    mem_we     <= 1'b1;
                    mem_addr   <= ptr[ADDR_W-1:0];
                    mem_wdata  <= {OPC_J, 26'(ptr[ADDR_W-1:0])};
                    ptr        <= ptr + ONE;
                    word_count <= word_count + ONE;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_stream_encoder.sv
`default_nettype none
// tb_instr_stream_encoder: two encoder instances (deep and 4-word memory) checked against a program-level model.
// Rev 1.0
module tb_instr_stream_encoder;

    localparam int M_IDLE = 0, M_ACC = 1, M_TERM = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        reset, start, finish, req_valid;
    logic [7:0]  base_addr;
    logic [3:0]  req_op;
    logic [4:0]  req_rs, req_rt, req_rd;
    logic [15:0] req_imm;
    logic [25:0] req_target;

    logic        ready0, we0, busy0, done0, eill0, eovf0;
    logic [7:0]  addr0;
    logic [31:0] wdata0;
    logic [8:0]  cnt0;
    logic        ready1, we1, busy1, done1, eill1, eovf1;
    logic [7:0]  addr1;
    logic [31:0] wdata1;
    logic [8:0]  cnt1;

    always #5 clk = ~clk;

    instr_stream_encoder #(.ADDR_W(8), .MEM_DEPTH(256)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .finish(finish),
        .req_valid(req_valid), .req_ready(ready0), .req_op(req_op), .req_rs(req_rs),
        .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm), .req_target(req_target),
        .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0), .word_count(cnt0),
        .busy(busy0), .done(done0), .err_illegal(eill0), .err_overflow(eovf0)
    );

    instr_stream_encoder #(.ADDR_W(8), .MEM_DEPTH(4)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .finish(finish),
        .req_valid(req_valid), .req_ready(ready1), .req_op(req_op), .req_rs(req_rs),
        .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm), .req_target(req_target),
        .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1), .word_count(cnt1),
        .busy(busy1), .done(done1), .err_illegal(eill1), .err_overflow(eovf1)
    );

    int checks = 0;
    int failures = 0;

    // Model state, one slot per instance.
    int          depth [2] = '{256, 4};
    int          m_mode [2];
    int          m_ptr [2];
    int          m_cnt [2];
    logic        m_we [2];
    logic [7:0]  m_addr [2];
    logic [31:0] m_wdata [2];
    logic        m_eill [2];
    logic        m_eovf [2];

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    logic        seen_done0;

    int opc_tab [16] = '{0, 0, 0, 0, 0, 0, 0, 35, 43, 4, 16, 36, 2, 31, 27, 0};
    int fn_tab  [7]  = '{32, 34, 36, 37, 42, 35, 20};

    function automatic logic [31:0] m_enc(input int op, input int rs, input int rt,
                                          input int rd, input int imm, input int tgt);
        logic [31:0] w;
        if (op <= 6)
            w = (32'(rs) << 21) + (32'(rt) << 16) + (32'(rd) << 11) + 32'(fn_tab[op]);
        else if (op <= 11)
            w = (32'(opc_tab[op]) << 26) + (32'(rs) << 21) + (32'(rt) << 16) + 32'(imm);
        else
            w = (32'(opc_tab[op]) << 26) + 32'(tgt);
        return w;
    endfunction

    function automatic logic m_ready(input int d);
        return (m_mode[d] == M_ACC) && (m_ptr[d] < depth[d] - 1);
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[dut%0d] at %0t: got 0x%0h, expected 0x%0h", nm, d, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = M_IDLE; m_ptr[d] = 0; m_cnt[d] = 0; m_we[d] = 1'b0;
            m_addr[d] = '0; m_wdata[d] = '0; m_eill[d] = 1'b0; m_eovf[d] = 1'b0;
        end
    endtask

    // Advance the model by one clock given the inputs currently applied.
    task automatic model_step();
        logic rdy;
        if (reset) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            rdy = m_ready(d);
            m_we[d] = 1'b0;
            case (m_mode[d])
                M_IDLE: if (start) begin
                    m_mode[d] = M_ACC; m_ptr[d] = int'(base_addr); m_cnt[d] = 0;
                    m_eill[d] = 1'b0; m_eovf[d] = 1'b0;
                end
                M_ACC: begin
                    if (req_valid && rdy) begin
                        if (req_op == 4'd15) m_eill[d] = 1'b1;
                        else begin
                            m_we[d] = 1'b1;
                            m_addr[d] = 8'(m_ptr[d]);
                            m_wdata[d] = m_enc(int'(req_op), int'(req_rs), int'(req_rt), int'(req_rd),
                                               int'(req_imm), int'(req_target));
                            m_ptr[d]++; m_cnt[d]++;
                        end
                    end
                    if (req_valid && !rdy) m_eovf[d] = 1'b1;
                    if (finish) m_mode[d] = M_TERM;
                end
                M_TERM: begin
                    m_we[d] = 1'b1;
                    m_addr[d] = 8'(m_ptr[d]);
                    m_wdata[d] = 32'h0800_0000 + 32'(m_ptr[d] % 256);
                    m_ptr[d]++; m_cnt[d]++;
                    m_mode[d] = M_DONE;
                end
                default: m_mode[d] = M_IDLE;
            endcase
        end
    endtask

    task automatic check_dut(input int d, input logic rdy, input logic bsy, input logic dn,
                             input logic we, input logic [7:0] a, input logic [31:0] wd,
                             input logic [8:0] c, input logic ei, input logic eo);
        chk("req_ready", d, 32'(rdy), 32'(m_ready(d)));
        chk("busy", d, 32'(bsy), 32'(m_mode[d] != M_IDLE));
        chk("done", d, 32'(dn), 32'(m_mode[d] == M_DONE));
        chk("mem_we", d, 32'(we), 32'(m_we[d]));
        chk("mem_addr", d, 32'(a), 32'(m_addr[d]));
        chk("mem_wdata", d, wd, m_wdata[d]);
        chk("word_count", d, 32'(c), 32'(m_cnt[d] % 512));
        chk("err_illegal", d, 32'(ei), 32'(m_eill[d]));
        chk("err_overflow", d, 32'(eo), 32'(m_eovf[d]));
    endtask

    task automatic compare_all();
        check_dut(0, ready0, busy0, done0, we0, addr0, wdata0, cnt0, eill0, eovf0);
        check_dut(1, ready1, busy1, done1, we1, addr1, wdata1, cnt1, eill1, eovf1);
        if (we0) mem0[addr0] = wdata0;
        if (we1) mem1[addr1] = wdata1;
        if (done0) seen_done0 = 1'b1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic send(input int op, input int rs, input int rt, input int rd,
                        input int imm, input int tgt, input logic fin);
        req_valid = 1'b1; req_op = 4'(op); req_rs = 5'(rs); req_rt = 5'(rt); req_rd = 5'(rd);
        req_imm = 16'(imm); req_target = 26'(tgt); finish = fin;
        tick();
        req_valid = 1'b0; finish = 1'b0;
    endtask

    task automatic begin_prog(input int base);
        start = 1'b1; base_addr = 8'(base);
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; finish = 1'b0; req_valid = 1'b0; base_addr = '0;
        req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0; req_target = '0;
        seen_done0 = 1'b0;
        for (int i = 0; i < 256; i++) begin mem0[i] = '0; mem1[i] = '0; end
        model_reset();
        #1;
        compare_all();
        tick();
        reset = 1'b0;
        tick();

        // Pin the model encoder against hand-computed words.
        chk("model_and", 0, m_enc(2, 1, 2, 3, 0, 0), 32'h0022_1824);
        chk("model_lw", 0, m_enc(7, 4, 5, 0, 8, 0), 32'h8C85_0008);
        chk("model_nandi", 0, m_enc(10, 1, 2, 0, 16'hFFFF, 0), 32'h4022_FFFF);
        chk("model_jmxor", 0, m_enc(5, 6, 0, 7, 0, 0), 32'h00C0_3823);
        chk("model_jalpc", 0, m_enc(13, 0, 0, 0, 0, 'h40), 32'h7C00_0040);

        // Single and-instruction program at 0x10.
        begin_prog('h10);
        send(2, 1, 2, 3, 0, 0, 1'b0);
        finish = 1'b1; tick(); finish = 1'b0;
        repeat (3) tick();
        chk("t1_word", 0, mem0['h10], 32'h0022_1824);
        chk("t1_term", 0, mem0['h11], 32'h0800_0011);
        chk("t1_count", 0, 32'(cnt0), 32'd2);
        chk("t1_done_seen", 0, 32'(seen_done0), 32'd1);

        // Back-to-back requests, finish alongside the second.
        begin_prog('h20);
        req_valid = 1'b1; req_op = 4'd7; req_rs = 5'd4; req_rt = 5'd5; req_imm = 16'h0008;
        tick();
        send(10, 1, 2, 0, 16'hFFFF, 0, 1'b1);
        repeat (3) tick();
        chk("t2_lw", 0, mem0['h20], 32'h8C85_0008);
        chk("t2_nandi", 0, mem0['h21], 32'h4022_FFFF);
        chk("t2_term", 0, mem0['h22], 32'h0800_0022);
        chk("t2_count", 0, 32'(cnt0), 32'd3);

        // Illegal op leaves the pointer; then jmxor and jalpc.
        begin_prog('h30);
        send(15, 1, 1, 1, 0, 0, 1'b0);
        send(5, 6, 0, 7, 0, 0, 1'b0);
        send(13, 0, 0, 0, 0, 'h40, 1'b1);
        repeat (3) tick();
        chk("t3_err_illegal", 0, 32'(eill0), 32'd1);
        chk("t3_jmxor", 0, mem0['h30], 32'h00C0_3823);
        chk("t3_jalpc", 0, mem0['h31], 32'h7C00_0040);
        chk("t3_term", 0, mem0['h32], 32'h0800_0032);
        begin_prog('h40);
        chk("t3_illegal_cleared", 0, 32'(eill0), 32'd0);
        finish = 1'b1; tick(); finish = 1'b0;
        repeat (3) tick();

        // Fill the 4-word instance and overflow it.
        begin_prog(0);
        repeat (3) send(0, 1, 2, 3, 0, 0, 1'b0);
        req_valid = 1'b1;
        repeat (2) tick();
        req_valid = 1'b0;
        finish = 1'b1; tick(); finish = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) chk("t4_fill", 1, mem1[i], 32'h0022_1820);
        chk("t4_term", 1, mem1[3], 32'h0800_0003);
        chk("t4_overflow", 1, 32'(eovf1), 32'd1);
        chk("t4_count", 1, 32'(cnt1), 32'd4);

        // Reset mid-stream with a request pending.
        begin_prog('h50);
        req_valid = 1'b1; req_op = 4'd0;
        repeat (2) tick();
        reset = 1'b1;
        #1;
        chk("t5_we_after_reset", 0, 32'(we0), 32'd0);
        chk("t5_busy_after_reset", 0, 32'(busy0), 32'd0);
        model_reset();
        compare_all();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        req_valid = 1'b0;

        // Randomized traffic on both instances.
        for (int n = 0; n < 4000; n++) begin
            start = ($urandom_range(0, 7) == 0);
            base_addr = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom_range(0, 255));
            finish = ($urandom_range(0, 24) == 0);
            req_valid = ($urandom_range(0, 3) != 0);
            req_op = 4'($urandom_range(0, 15));
            req_rs = 5'($urandom); req_rt = 5'($urandom); req_rd = 5'($urandom);
            req_imm = 16'($urandom); req_target = 26'($urandom);
            if ($urandom_range(0, 399) == 0) do_reset();
            else tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
